// File: rtl/cam_host_controller_pkg.sv
// Shared encodings for the CAM host controller: command opcodes, FSM states
// and default key/address widths.
package cam_host_controller_pkg;

  localparam int KEY_W_DEF  = 8;
  localparam int ADDR_W_DEF = 4;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_SEARCH = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WR       = 3'd1;
  localparam logic [2:0] ST_SR_ISSUE = 3'd2;
  localparam logic [2:0] ST_SR_WAIT  = 3'd3;
  localparam logic [2:0] ST_RSP      = 3'd4;
  localparam logic [2:0] ST_CLR      = 3'd5;

endpackage

// File: rtl/cam_host_controller.sv
// Initiator for one CAM: sequences wen/ren strobes for WRITE / SEARCH / CLEAR
// commands and returns one registered result per SEARCH.
module cam_host_controller
  import cam_host_controller_pkg::*;
#(
  parameter int               KEY_W     = KEY_W_DEF,
  parameter int               ADDR_W    = ADDR_W_DEF,
  parameter logic [KEY_W-1:0] CLEAR_KEY = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [KEY_W-1:0]  cmd_key,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_hit,
  output logic              busy,
  output logic              cam_wen,
  output logic              cam_ren,
  output logic [KEY_W-1:0]  cam_din,
  output logic [ADDR_W-1:0] cam_addr,
  input  logic [ADDR_W-1:0] cam_dout,
  input  logic              cam_hit
);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_ctr;
  logic              r_cam_wen;
  logic              r_cam_ren;
  logic [KEY_W-1:0]  r_cam_din;
  logic [ADDR_W-1:0] r_cam_addr;
  logic              r_rsp_valid;
  logic              r_rsp_hit;
  logic [ADDR_W-1:0] r_rsp_addr;

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign cam_wen   = r_cam_wen;
  assign cam_ren   = r_cam_ren;
  assign cam_din   = r_cam_din;
  assign cam_addr  = r_cam_addr;
  assign rsp_valid = r_rsp_valid;
  assign rsp_hit   = r_rsp_hit;
  assign rsp_addr  = r_rsp_addr;

  // Strobes are set on the edge that enters a state, so each state's cycle
  // already presents its CAM access; wen and ren live in disjoint states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ctr       <= '0;
      r_cam_wen   <= 1'b0;
      r_cam_ren   <= 1'b0;
      r_cam_din   <= '0;
      r_cam_addr  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_addr  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_WRITE: begin
                r_state    <= ST_WR;
                r_cam_wen  <= 1'b1;
                r_cam_din  <= cmd_key;
                r_cam_addr <= cmd_addr;
              end
              OP_SEARCH: begin
                r_state   <= ST_SR_ISSUE;
                r_cam_ren <= 1'b1;
                r_cam_din <= cmd_key;
              end
              OP_CLEAR: begin
                r_state    <= ST_CLR;
                r_ctr      <= '0;
                r_cam_wen  <= 1'b1;
                r_cam_din  <= CLEAR_KEY;
                r_cam_addr <= '0;
              end
              default: ;
            endcase
          end
        end
        ST_WR: begin
          r_cam_wen <= 1'b0;
          r_state   <= ST_IDLE;
        end
        ST_SR_ISSUE: begin
          r_cam_ren <= 1'b0;
          r_state   <= ST_SR_WAIT;
        end
        ST_SR_WAIT: begin
          // A miss reports address 0 regardless of what the CAM leaves on dout.
          r_rsp_valid <= 1'b1;
          r_rsp_hit   <= cam_hit;
          r_rsp_addr  <= cam_hit ? cam_dout : '0;
          r_state     <= ST_RSP;
        end
        ST_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        ST_CLR: begin
          // Counter wrapping back to 0 ends the walk; one trailing cycle with wen low.
          if (!r_cam_wen) begin
            r_state <= ST_IDLE;
          end else begin
            r_ctr      <= r_ctr + 1'b1;
            r_cam_addr <= r_ctr + 1'b1;
            if (r_ctr == '1) r_cam_wen <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cam_wen <= 1'b0;
          r_cam_ren <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_host_controller.sv
// Bench for cam_host_controller: behavioural CAM on the strobe side plus a
// command-level reference of the CAM contents for expected search results.
module tb_cam_host_controller;
  import cam_host_controller_pkg::*;

  localparam int KEY_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH = 16;
  localparam logic [KEY_W-1:0] CLEAR_KEY = 8'h00;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'b00;
  logic [KEY_W-1:0]  cmd_key = '0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_hit;
  logic              busy;
  logic              cam_wen;
  logic              cam_ren;
  logic [KEY_W-1:0]  cam_din;
  logic [ADDR_W-1:0] cam_addr;
  logic [ADDR_W-1:0] cam_dout = '0;
  logic              cam_hit = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [KEY_W-1:0] cam_mem [DEPTH];
  logic [KEY_W-1:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  cam_host_controller #(.KEY_W(KEY_W), .ADDR_W(ADDR_W), .CLEAR_KEY(CLEAR_KEY)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_key(cmd_key), .cmd_addr(cmd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_hit(rsp_hit),
    .busy(busy), .cam_wen(cam_wen), .cam_ren(cam_ren), .cam_din(cam_din),
    .cam_addr(cam_addr), .cam_dout(cam_dout), .cam_hit(cam_hit)
  );

  // Behavioural CAM: registered lookup, highest matching address wins,
  // dout carries junk on a miss.
  function automatic logic [ADDR_W:0] cam_lookup(input logic [KEY_W-1:0] k);
    logic [ADDR_W:0] r;
    r = {1'b0, ADDR_W'($urandom_range(1, DEPTH - 1))};
    for (int i = 0; i < DEPTH; i++)
      if (cam_mem[i] == k) r = {1'b1, ADDR_W'(i)};
    return r;
  endfunction

  always @(posedge clk) begin
    if (cam_wen) cam_mem[cam_addr] <= cam_din;
    if (cam_ren) {cam_hit, cam_dout} <= cam_lookup(cam_din);
  end

  function automatic logic [ADDR_W:0] ref_search(input logic [KEY_W-1:0] k);
    logic [ADDR_W:0] r;
    r = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ref_mem[i] == k) r = {1'b1, ADDR_W'(i)};
    return r;
  endfunction

  task automatic send(input logic [1:0] op, input logic [KEY_W-1:0] key, input logic [ADDR_W-1:0] addr);
    int t;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_key = key; cmd_addr = addr;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: cmd_ready=%0b required 1", cmd_ready);
    end
    if (op == OP_WRITE) ref_mem[addr] = key;
    if (op == OP_CLEAR) for (int i = 0; i < DEPTH; i++) ref_mem[i] = CLEAR_KEY;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!cmd_ready && t < 60) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      vectors++; miscompares++;
      $display("FAIL idle_timeout: cmd_ready=%0b required 1", cmd_ready);
    end
  endtask

  // Returns the response seen on the channel and the accept-to-valid latency.
  task automatic do_search(input logic [KEY_W-1:0] key, input int hold,
                           output logic [ADDR_W:0] res, output int lat);
    int t;
    send(OP_SEARCH, key, '0);
    t = 0;
    while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
    lat = t + 1;
    if (!rsp_valid) begin
      vectors++; miscompares++;
      $display("FAIL rsp_timeout: rsp_valid=%0b required 1", rsp_valid);
    end
    repeat (hold) @(negedge clk);
    res = {rsp_hit, rsp_addr};
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [27:0] rst_vec;
    int t;
    rst_vec = {1'b1, 5'b0, 4'h0, 8'h00, 4'h0, 6'b0};
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({cmd_ready, rsp_valid, rsp_hit, busy, cam_wen, cam_ren, rsp_addr, cam_din, cam_addr, 6'b0} !== rst_vec) begin
      miscompares++;
      $display("FAIL reset_values: got %h required %h",
               {cmd_ready, rsp_valid, rsp_hit, busy, cam_wen, cam_ren, rsp_addr, cam_din, cam_addr, 6'b0}, rst_vec);
    end
    rst_n = 1'b1;
    send(OP_CLEAR, 8'h00, '0);
    t = 0;
    while (!(cam_wen && cam_addr == 4'd5) && t < 40) begin @(negedge clk); t++; end
    vectors++;
    if (!(cam_wen && cam_addr == 4'd5)) begin
      miscompares++;
      $display("FAIL clear_reach_ctr5: cam_addr=%0d cam_wen=%0b required 5/1", cam_addr, cam_wen);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({cmd_ready, rsp_valid, rsp_hit, busy, cam_wen, cam_ren, rsp_addr, cam_din, cam_addr, 6'b0} !== rst_vec) begin
      miscompares++;
      $display("FAIL reset_mid_clear: got %h required %h",
               {cmd_ready, rsp_valid, rsp_hit, busy, cam_wen, cam_ren, rsp_addr, cam_din, cam_addr, 6'b0}, rst_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_after_release: cmd_ready=%0b busy=%0b required 1/0", cmd_ready, busy);
    end
    send(OP_CLEAR, 8'h00, '0);
    wait_idle();
  endtask

  task automatic test_miss();
    logic [ADDR_W:0] res;
    int lat;
    do_search(8'd35, 0, res, lat);
    vectors++;
    if (res !== ref_search(8'd35)) begin
      miscompares++;
      $display("FAIL miss_result: hit/addr=%h required %h", res, ref_search(8'd35));
    end
    vectors++;
    if (lat != 3) begin
      miscompares++;
      $display("FAIL miss_latency: got %0d cycles required 3", lat);
    end
  endtask

  task automatic test_priority();
    logic [ADDR_W:0] res;
    int lat;
    send(OP_WRITE, 8'd8, 4'd7);
    send(OP_WRITE, 8'd8, 4'd9);
    do_search(8'd8, 0, res, lat);
    vectors++;
    if (res !== ref_search(8'd8)) begin
      miscompares++;
      $display("FAIL priority_highest: hit/addr=%h required %h", res, ref_search(8'd8));
    end
  endtask

  task automatic test_backpressure();
    logic [ADDR_W:0] exp;
    int t, err;
    send(OP_WRITE, 8'd4, 4'd2);
    send(OP_SEARCH, 8'd4, '0);
    exp = ref_search(8'd4);
    t = 0;
    while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
    cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_key = 8'd99; cmd_addr = 4'd3;
    err = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid !== 1'b1 || {rsp_hit, rsp_addr} !== exp || cmd_ready !== 1'b0 || cam_wen !== 1'b0)
        err++;
      @(negedge clk);
    end
    vectors++;
    if (err != 0) begin
      miscompares++;
      $display("FAIL backpressure_hold: %0d bad cycles, last hit/addr=%h required %h", err, {rsp_hit, rsp_addr}, exp);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure_release: rsp_valid=%0b cmd_ready=%0b required 0/1", rsp_valid, cmd_ready);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || cam_wen !== 1'b0) begin
      miscompares++;
      $display("FAIL held_cmd_ignored: busy=%0b cam_wen=%0b required 0/0", busy, cam_wen);
    end
  endtask

  task automatic test_clear();
    logic [ADDR_W:0] res;
    int lat, wen_cycles, busy_cycles, bad;
    send(OP_WRITE, 8'd33, 4'd15);
    send(OP_CLEAR, 8'h00, '0);
    wen_cycles = 0; busy_cycles = 0; bad = 0;
    for (int t = 0; t < 40; t++) begin
      if (!busy) break;
      busy_cycles++;
      if (cam_ren || (cam_wen && (cam_addr !== ADDR_W'(wen_cycles) || cam_din !== CLEAR_KEY))) bad++;
      if (cam_wen) wen_cycles++;
      @(negedge clk);
    end
    vectors++;
    if (wen_cycles != DEPTH) begin
      miscompares++;
      $display("FAIL clear_wen_cycles: got %0d required %0d", wen_cycles, DEPTH);
    end
    vectors++;
    if (busy_cycles != DEPTH + 1) begin
      miscompares++;
      $display("FAIL clear_busy_cycles: got %0d required %0d", busy_cycles, DEPTH + 1);
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL clear_addr_walk: %0d bad cycles required 0", bad);
    end
    do_search(8'd33, 1, res, lat);
    vectors++;
    if (res !== ref_search(8'd33)) begin
      miscompares++;
      $display("FAIL clear_old_key: hit/addr=%h required %h", res, ref_search(8'd33));
    end
    do_search(CLEAR_KEY, 0, res, lat);
    vectors++;
    if (res !== ref_search(CLEAR_KEY)) begin
      miscompares++;
      $display("FAIL clear_key_hit: hit/addr=%h required %h", res, ref_search(CLEAR_KEY));
    end
  endtask

  task automatic test_reserved();
    int bad;
    send(2'b11, 8'd77, 4'd6);
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reserved_ready: cmd_ready=%0b busy=%0b required 1/0", cmd_ready, busy);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (cam_wen || cam_ren || rsp_valid) bad++;
      @(negedge clk);
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL reserved_no_effect: %0d cycles with strobe/response required 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W:0] res;
    logic [KEY_W-1:0] k;
    logic [ADDR_W-1:0] a;
    int lat;
    for (int i = 0; i < 3; i++) begin
      k = KEY_W'($urandom_range(100, 200));
      a = ADDR_W'($urandom_range(0, DEPTH - 1));
      send(OP_WRITE, k, a);
      do_search(k, 0, res, lat);
      vectors++;
      if (res !== ref_search(k) || res[ADDR_W] !== 1'b1) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: hit/addr=%h required %h", i, res, ref_search(k));
      end
    end
  endtask

  task automatic test_random();
    logic [ADDR_W:0] res;
    logic [KEY_W-1:0] k;
    int lat, r;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 19);
      k = KEY_W'($urandom_range(0, 7));
      if (r < 9) send(OP_WRITE, k, ADDR_W'($urandom_range(0, DEPTH - 1)));
      else if (r < 17) begin
        do_search(k, $urandom_range(0, 3), res, lat);
        vectors++;
        if (res !== ref_search(k)) begin
          miscompares++;
          $display("FAIL random_search[%0d] key=%0d: hit/addr=%h required %h", i, k, res, ref_search(k));
        end
      end
      else if (r == 17) send(2'b11, k, '0);
      else begin
        send(OP_CLEAR, '0, '0);
        wait_idle();
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      cam_mem[i] = '0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_miss();
    test_priority();
    test_backpressure();
    test_clear();
    test_reserved();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
